// File: rtl/reg_file_rd.sv
// Integer register file: 32 x XLEN, two registered read ports with write bypass,
// one write port, and a pending-write scoreboard feeding hazard logic.
module reg_file_rd #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs1_rden,
  input  logic              rs2_rden,
  input  logic              dec_valid,
  input  logic              rd_issue_en,
  input  logic [ADDR_W-1:0] rd_issue_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_out_valid
);

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  logic            wr_ok;
  logic            issue_ok;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            rs1_live;
  logic            rs2_live;
  logic [XLEN-1:0] rs1_nxt;
  logic [XLEN-1:0] rs2_nxt;
  logic            rs1_busy_nxt;
  logic            rs2_busy_nxt;

  assign wr_ok    = wr_en && (wr_addr != '0);
  assign issue_ok = rd_issue_en && dec_valid && !stall && !flush && (rd_issue_addr != '0);

  assign rs1_live = rs1_rden && (rs1_addr != '0);
  assign rs2_live = rs2_rden && (rs2_addr != '0);
  assign rs1_hit  = wr_en && (wr_addr == rs1_addr);
  assign rs2_hit  = wr_en && (wr_addr == rs2_addr);

  always_comb begin
    rs1_nxt      = '0;
    rs2_nxt      = '0;
    rs1_busy_nxt = 1'b0;
    rs2_busy_nxt = 1'b0;
    if (rs1_live) begin
      rs1_nxt      = rs1_hit ? wr_data : regs[rs1_addr];
      rs1_busy_nxt = busy[rs1_addr] && !rs1_hit;
    end
    if (rs2_live) begin
      rs2_nxt      = rs2_hit ? wr_data : regs[rs2_addr];
      rs2_busy_nxt = busy[rs2_addr] && !rs2_hit;
    end
  end

  // Set is applied after clear so a new producer supersedes a retiring one.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[wr_addr] = 1'b0;
    if (issue_ok)
      busy_nxt[rd_issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok)
        regs[wr_addr] <= wr_data;
      busy <= busy_nxt;
    end
  end

  // Stall freezes the operand slot outright, even against writes that land meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_data     <= '0;
      rs2_data     <= '0;
      rs1_busy     <= 1'b0;
      rs2_busy     <= 1'b0;
      rd_out_valid <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        rs1_data     <= '0;
        rs2_data     <= '0;
        rs1_busy     <= 1'b0;
        rs2_busy     <= 1'b0;
        rd_out_valid <= 1'b0;
      end else begin
        rs1_data     <= rs1_nxt;
        rs2_data     <= rs2_nxt;
        rs1_busy     <= rs1_busy_nxt;
        rs2_busy     <= rs2_busy_nxt;
        rd_out_valid <= dec_valid;
      end
    end
  end

endmodule

// File: doc/reg_file_rd.md
Name: reg_file_rd

Overview:
- Architectural integer register file: 32 x XLEN entries, two synchronous read ports, one write port.
- Sits directly downstream of decode register control. Consumes rs1/rs2 addresses and read enables; produces registered operands for the execute stage.
- Write port is driven by writeback. A write-to-read bypass covers same-cycle write/read collisions.
- A per-register pending-write scoreboard flags sources whose producer has not yet written back, for use by hazard logic.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; x0 is hardwired to zero.
- ADDR_W, 5, register address width; equals clog2(NUM_REGS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all read outputs; suppress read sampling and rd issue.
- flush  in  1  squash the current decode slot.
- rs1_addr  in  ADDR_W  source 1 address from decode.
- rs2_addr  in  ADDR_W  source 2 address from decode.
- rs1_rden  in  1  source 1 read enable.
- rs2_rden  in  1  source 2 read enable.
- dec_valid  in  1  decode slot holds a real instruction.
- rd_issue_en  in  1  the instruction in decode writes a destination.
- rd_issue_addr  in  ADDR_W  destination of the decoding instruction.
- wr_en  in  1  writeback write enable.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  XLEN  writeback data.
- rs1_data  out  XLEN  registered source 1 operand.
- rs2_data  out  XLEN  registered source 2 operand.
- rs1_busy  out  1  registered: source 1 has an outstanding writer.
- rs2_busy  out  1  registered: source 2 has an outstanding writer.
- rd_out_valid  out  1  registered: outputs correspond to a valid instruction.

Behaviour:
- Reset: on rst high, asynchronously clear all registers and all busy bits. rs1_data, rs2_data, rs1_busy, rs2_busy and rd_out_valid all go to 0 and hold while rst is high.
- Reset deasserted mid-stream: the first read after reset returns 0 for every address.
- Write port:
  - Writes on the rising edge when wr_en=1 and wr_addr!=0.
  - Writes to x0 are discarded; x0 always reads 0.
  - The write port is never affected by stall or flush.
- Read latency is 1 cycle. On an edge with stall=0, for each port n:
  - rsn_data <= 0 if rsn_rden=0 or rsn_addr=0.
  - Otherwise rsn_data <= wr_data when wr_en=1 and wr_addr==rsn_addr (bypass).
  - Otherwise rsn_data <= regs[rsn_addr].
- Scoreboard (one busy bit per register, bit 0 tied to 0):
  - Set: rd_issue_en & dec_valid & !stall & !flush & rd_issue_addr!=0 sets busy[rd_issue_addr].
  - Clear: wr_en & wr_addr!=0 clears busy[wr_addr].
  - Same-cycle set and clear of the same register: set wins (the new producer supersedes).
- Busy outputs, on an edge with stall=0:
  - rsn_busy <= rsn_rden & rsn_addr!=0 & busy[rsn_addr] & !(wr_en & wr_addr==rsn_addr).
  - The decoding instruction's own rd issue never affects its own busy outputs.
- Valid output, on an edge with stall=0: rd_out_valid <= dec_valid & !flush.
- Flush, on an edge with stall=0 and flush=1:
  - rs1_data, rs2_data, rs1_busy, rs2_busy and rd_out_valid all become 0.
  - No busy bit is set that cycle.
  - Existing busy bits are retained; in-flight writers still write back.
- Stall:
  - When stall=1, all five read outputs hold their values. Stall has priority over flush.
  - The write port and scoreboard clears still operate.
  - A write that completes during a stall is NOT reflected in held outputs. Downstream re-reads after the stall releases.
- No combinational path from any input to any output.

Test Plan:
- Reset, then read x5 and x0 with rden=1 -> rs1_data=0, rs2_data=0, rd_out_valid=1 after 1 cycle.
- Write x7=0xDEADBEEF; next cycle read rs1=x7 -> rs1_data=0xDEADBEEF. Write x0=0x1234, read x0 -> 0.
- Same-cycle bypass: wr x3=0xA5A5A5A5 while reading rs2=x3 -> rs2_data=0xA5A5A5A5, rs2_busy=0.
- Scoreboard:
  - Issue rd=x9, then read rs1=x9 next cycle -> rs1_busy=1.
  - Writeback x9=0x55 and re-read -> busy=0, data=0x55.
  - Same-cycle issue x9 and writeback x9 -> busy[x9] stays 1.
- Stall and flush:
  - stall=1 for 3 cycles while rs1_addr changes -> outputs frozen at prior values.
  - flush=1 with issue rd=x4 -> all outputs 0 and busy[x4] remains 0.
- Async reset asserted mid-cycle with x7=0xDEADBEEF and busy[x9]=1 -> outputs 0 immediately (before next edge); post-reset reads of x7 return 0 and x9 shows busy=0.
